// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO family (sync, and later async/multichannel).
//   clog2()          : ceiling log2, usable in constant expressions
//   FIFO_MODE_STD    : registered read, dout updates the cycle after rd_en
//   FIFO_MODE_FWFT   : first-word-fall-through, head word shown on dout
package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Storage array for sync_fifo_param: DATA_W x DEPTH simple dual-port memory.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : asynchronous read address
//   rdata : read data (combinational from raddr)
// No reset on purpose so tools can map it to distributed/block RAM.
module fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with full-depth occupancy.
//   clk, rst      : clock (rising edge), async active-high reset
//   wr_en, din    : write request and data
//   rd_en         : read request (FWFT: pop the head word)
//   dout          : read data
//   full, empty   : count == DEPTH / count == 0
//   almost_full   : count >= AF_LEVEL
//   almost_empty  : count <= AE_LEVEL
//   count         : occupancy 0..DEPTH
//   overflow      : one-cycle pulse, write rejected
//   underflow     : one-cycle pulse, read rejected
// All flags are registered from the next-state count, so they always agree
// with count and have no combinational path from the enables.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter  int DATA_W   = 8,
  parameter  int DEPTH    = 16,
  parameter  int AF_LEVEL = DEPTH - 2,
  parameter  int AE_LEVEL = 2,
  parameter  int FWFT     = FIFO_MODE_STD,
  localparam int PTR_W    = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [PTR_W:0]    count,
  output logic              overflow,
  output logic              underflow
);

  typedef logic [PTR_W:0] cnt_t;

  localparam cnt_t DEPTH_CNT = cnt_t'(DEPTH);
  localparam cnt_t AF_CNT    = cnt_t'(AF_LEVEL);
  localparam cnt_t AE_CNT    = cnt_t'(AE_LEVEL);

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  cnt_t              count_q;
  cnt_t              count_nxt;
  logic              full_q;
  logic              empty_q;
  logic              almost_full_q;
  logic              almost_empty_q;
  logic              overflow_q;
  logic              underflow_q;
  logic              rd_acc;
  logic              wr_acc;
  logic [DATA_W-1:0] mem_rdata;

  // A write while full is only safe when the head slot is freed this cycle.
  assign rd_acc = rd_en & ~empty_q;
  assign wr_acc = wr_en & (~full_q | rd_acc);

  always_comb begin
    count_nxt = count_q;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count_q + 1'b1;
      2'b01:   count_nxt = count_q - 1'b1;
      default: count_nxt = count_q;
    endcase
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (din),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count_q        <= '0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count_q        <= count_nxt;
      full_q         <= (count_nxt == DEPTH_CNT);
      empty_q        <= (count_nxt == '0);
      almost_full_q  <= (count_nxt >= AF_CNT);
      almost_empty_q <= (count_nxt <= AE_CNT);
      overflow_q     <= wr_en & ~wr_acc;
      underflow_q    <= rd_en & ~rd_acc;
    end
  end

  generate
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      // Head word is read straight from the array; empty is registered, so a
      // word written on edge N is shown together with empty=0 after edge N.
      assign dout = empty_q ? '0 : mem_rdata;
    end else begin : g_std
      logic [DATA_W-1:0] dout_q;

      // When full with both enables, wr_ptr == rd_ptr: the old head is
      // captured here before the array slot is overwritten on the same edge.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dout_q <= '0;
        end else if (rd_acc) begin
          dout_q <= mem_rdata;
        end
      end

      assign dout = dout_q;
    end
  endgenerate

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule
